// File: rtl/sync_fifo_stream_reader.sv
// sync_fifo_stream_reader
// Read-side adapter for the synchronous FIFO. It issues read strobes, absorbs
// the FIFO's one-cycle registered read latency through a 2-entry output
// buffer, and presents words on a valid/ready stream with no bubbles. A flush
// request discards everything buffered, in flight or still queued in the FIFO.
// Optional feature: define SYNC_FIFO_RD_CNT_EN to add a 16-bit rd_count output
// that counts accepted output words.
module sync_fifo_stream_reader #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    input  logic                  flush,
    output logic                  busy
`ifdef SYNC_FIFO_RD_CNT_EN
    ,
    output logic [15:0]           rd_count
`endif
);

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                state_reg;
    state_t                state_next;
    logic [1:0]            occ_reg;
    logic [1:0]            occ_next;
    logic [1:0]            occ_after_pop;
    logic [1:0]            pending;
    logic                  inflight_reg;
    logic                  m_valid_reg;
    logic                  m_valid_next;
    logic                  busy_reg;
    logic                  pop;
    logic                  capture;
    logic                  clear_buf;
    logic [DATA_WIDTH-1:0] entry_q [0:1];

    // A word leaves the buffer whenever the head is valid and accepted.
    assign pop = m_valid_reg && m_ready;

    // Words that will still be held or in flight after this cycle's pop,
    // before counting any new read; 2-bit arithmetic, never exceeds 2.
    always_comb begin
        pending = occ_reg + {1'b0, inflight_reg} - {1'b0, pop};
    end

    // Read strobe: in RUN only when a buffer slot is guaranteed for the
    // returned word; in FLUSH drain unconditionally. Held low during reset.
    always_comb begin
        fifo_rd_en = 1'b0;
        if (rst_n) begin
            case (state_reg)
                ST_RUN:   fifo_rd_en = !fifo_empty && (pending < 2'd2);
                ST_FLUSH: fifo_rd_en = !fifo_empty;
                default:  fifo_rd_en = 1'b0;
            endcase
        end
    end

    // Next-state logic: enter FLUSH on request, return to RUN once the FIFO
    // is empty and nothing is in flight (which also means no strobe now).
    always_comb begin
        state_next = state_reg;
        clear_buf  = 1'b0;
        case (state_reg)
            ST_RUN: begin
                if (flush) begin
                    state_next = ST_FLUSH;
                    clear_buf  = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (fifo_empty && !inflight_reg) begin
                    state_next = ST_RUN;
                end
            end
            default: state_next = ST_RUN;
        endcase
    end

    // Occupancy bookkeeping: remove the popped word, then append the word
    // returning from the FIFO (only kept in RUN; FLUSH discards it).
    always_comb begin
        occ_after_pop = occ_reg - {1'b0, pop};
        capture       = (state_reg == ST_RUN) && inflight_reg;
        if (clear_buf || (state_reg == ST_FLUSH)) begin
            occ_next = 2'd0;
        end else begin
            occ_next = occ_after_pop + {1'b0, capture};
        end
        m_valid_next = (occ_next != 2'd0);
    end

    // Buffer entries. Entry 0 is the head driving m_data. On a pop with two
    // words held, entry 1 shifts into entry 0; a capture lands in the first
    // free slot after that shift. With only one word held, a pop leaves the
    // head register untouched so m_data does not glitch to stale contents.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_entry
            logic [DATA_WIDTH-1:0] entry_reg;
            logic [DATA_WIDTH-1:0] entry_next;
            logic [DATA_WIDTH-1:0] shifted;

            if (gi == 0) begin : g_head
                assign shifted = (pop && (occ_reg == 2'd2)) ? entry_q[1] : entry_reg;
            end else begin : g_tail
                assign shifted = entry_reg;
            end

            // Per-entry next value: clear on flush, load on capture, else shift/hold.
            always_comb begin
                entry_next = shifted;
                if (clear_buf) begin
                    entry_next = '0;
                end else if (capture && (occ_after_pop == 2'(gi))) begin
                    entry_next = fifo_dout;
                end
            end

            // Per-entry storage register.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    entry_reg <= '0;
                end else begin
                    entry_reg <= entry_next;
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    // Control registers: state, occupancy, in-flight flag, valid and busy.
    // Clearing inflight at reset guarantees no capture the following cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_RUN;
            occ_reg      <= 2'd0;
            inflight_reg <= 1'b0;
            m_valid_reg  <= 1'b0;
            busy_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            occ_reg      <= occ_next;
            inflight_reg <= fifo_rd_en;
            m_valid_reg  <= m_valid_next;
            busy_reg     <= (state_next == ST_FLUSH);
        end
    end

    assign m_valid = m_valid_reg;
    assign m_data  = entry_q[0];
    assign busy    = busy_reg;

`ifdef SYNC_FIFO_RD_CNT_EN
    logic [15:0] rd_count_reg;

    // Delivered-word counter; restarts on entering FLUSH, so a word popped
    // in the flush cycle itself is not counted. Wraps naturally at 16 bits.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_count_reg <= 16'd0;
        end else if (clear_buf) begin
            rd_count_reg <= 16'd0;
        end else if (pop) begin
            rd_count_reg <= rd_count_reg + 16'd1;
        end
    end

    assign rd_count = rd_count_reg;
`endif

endmodule

// File: tb/tb_sync_fifo_stream_reader.sv
// Testbench for sync_fifo_stream_reader: a behavioural FIFO with registered
// read data feeds the DUT; directed tables and sequences check the stream.
module tb_sync_fifo_stream_reader;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout = '0;
    logic          fifo_rd_en;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic          flush;
    logic          busy;
`ifdef SYNC_FIFO_RD_CNT_EN
    logic [15:0]   rd_count;
`endif

    int checks   = 0;
    int failures = 0;

    // Behavioural FIFO model: stimulus pushes at the falling edge, reads are
    // served at the rising edge with one cycle of registered latency.
    logic [DW-1:0] mem [0:4095];
    int            wr_ptr       = 0;
    int            rd_ptr       = 0;
    int            reads_issued = 0;

    assign fifo_empty = (rd_ptr >= wr_ptr);

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (fifo_rd_en) begin
            fifo_dout    <= mem[rd_ptr[11:0]];
            rd_ptr       <= rd_ptr + 1;
            reads_issued <= reads_issued + 1;
        end
    end

    sync_fifo_stream_reader #(.DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_rd_en (fifo_rd_en),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .flush      (flush),
        .busy       (busy)
`ifdef SYNC_FIFO_RD_CNT_EN
        ,
        .rd_count   (rd_count)
`endif
    );

    typedef struct {
        logic          m_ready;
        logic          exp_rd_en;
        logic          exp_valid;
        logic [DW-1:0] exp_data;
        logic          chk_data;
    } vec_t;

    vec_t vecs [0:18];

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
        end else begin
            $display("ok   %s cycle=%0d value=0x%0h", name, cyc, act);
        end
    endtask

    task automatic push(input logic [DW-1:0] v);
        mem[wr_ptr[11:0]] = v;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n   = 1'b0;
        m_ready = 1'b0;
        flush   = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    logic [DW-1:0] sent [0:199];

    initial begin
        int popped;
        int r0;
        int outstanding;
        int cyc;
        logic exp_rd;
        logic exp_mv;
        logic exp_busy;

        rst_n   = 1'b0;
        m_ready = 1'b0;
        flush   = 1'b0;

        // ---------------- Test 1: reset then idle ----------------
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            #1;
            chk("idle_rd_en", c, 32'(fifo_rd_en), 32'd0);
            chk("idle_valid", c, 32'(m_valid), 32'd0);
            chk("idle_data",  c, 32'(m_data), 32'd0);
            chk("idle_busy",  c, 32'(busy), 32'd0);
`ifdef SYNC_FIFO_RD_CNT_EN
            chk("idle_count", c, 32'(rd_count), 32'd0);
`endif
        end

        // ---------------- Test 2: streaming 0x01..0x10 ----------------
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) begin
                for (int k = 1; k <= 16; k++) push(8'(k));
            end
            m_ready = 1'b1;
            #1;
            exp_rd = (c < 16);
            exp_mv = (c >= 2) && (c <= 17);
            chk("stream_rd_en", c, 32'(fifo_rd_en), 32'(exp_rd));
            chk("stream_valid", c, 32'(m_valid), 32'(exp_mv));
            if (exp_mv) chk("stream_data", c, 32'(m_data), 32'(c - 1));
        end

        // ---------------- Test 3: backpressure table ----------------
        vecs[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b1};
        for (int i = 2; i <= 9; i++) vecs[i] = '{1'b0, 1'b0, 1'b1, 8'hA0, 1'b1};
        vecs[10] = '{1'b1, 1'b1, 1'b1, 8'hA0, 1'b1};
        vecs[11] = '{1'b1, 1'b1, 1'b1, 8'hA1, 1'b1};
        vecs[12] = '{1'b1, 1'b1, 1'b1, 8'hA2, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 1'b1, 8'hA3, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 8'hA4, 1'b1};
        vecs[15] = '{1'b1, 1'b1, 1'b1, 8'hA5, 1'b1};
        vecs[16] = '{1'b1, 1'b0, 1'b1, 8'hA6, 1'b1};
        vecs[17] = '{1'b1, 1'b0, 1'b1, 8'hA7, 1'b1};
        vecs[18] = '{1'b1, 1'b0, 1'b0, 8'hA7, 1'b0};
        do_reset();
        for (int i = 0; i < 19; i++) begin
            @(negedge clk);
            if (i == 0) begin
                for (int k = 0; k < 8; k++) push(8'hA0 + 8'(k));
            end
            m_ready = vecs[i].m_ready;
            #1;
            chk("bp_rd_en", i, 32'(fifo_rd_en), 32'(vecs[i].exp_rd_en));
            chk("bp_valid", i, 32'(m_valid), 32'(vecs[i].exp_valid));
            chk("bp_busy",  i, 32'(busy), 32'd0);
            if (vecs[i].chk_data) chk("bp_data", i, 32'(m_data), 32'(vecs[i].exp_data));
        end

        // ---------------- Test 4: random words, random m_ready ----------------
        for (int i = 0; i < 200; i++) sent[i] = 8'($urandom);
        begin
            int pushed;
            pushed = 0;
            popped = 0;
            r0     = reads_issued;
            cyc    = 0;
            while ((popped < 200) && (cyc < 4000)) begin
                @(negedge clk);
                if ((pushed < 200) && ($urandom_range(0, 1) == 1)) begin
                    push(sent[pushed]);
                    pushed++;
                end
                m_ready = ($urandom_range(0, 1) == 1);
                #1;
                outstanding = (reads_issued - r0) - popped;
                if (fifo_rd_en && fifo_empty)
                    chk("rand_rd_en_while_empty", cyc, 32'(fifo_rd_en && fifo_empty), 32'd0);
                if (outstanding > 2)
                    chk("rand_outstanding_le_2", cyc, 32'(outstanding), 32'd2);
                if (m_valid && m_ready) begin
                    chk("rand_data", popped, 32'(m_data), 32'(sent[popped]));
                    popped++;
                end
                cyc++;
            end
            chk("rand_words_delivered", cyc, 32'(popped), 32'd200);
        end

        // ---------------- Test 5: flush after 3 pops ----------------
        do_reset();
        for (int c = 0; c < 23; c++) begin
            @(negedge clk);
            if (c == 0) begin
                for (int k = 0; k < 12; k++) push(8'h30 + 8'(k));
            end
            if (c == 16) begin
                for (int k = 0; k < 4; k++) push(8'h50 + 8'(k));
            end
            m_ready = 1'b1;
            flush   = (c == 5) || (c == 8);
            #1;
            exp_rd   = (c <= 11) || ((c >= 16) && (c <= 19));
            exp_busy = (c >= 6) && (c <= 13);
            exp_mv   = ((c >= 2) && (c <= 5)) || ((c >= 18) && (c <= 21));
            chk("flush_rd_en", c, 32'(fifo_rd_en), 32'(exp_rd));
            chk("flush_busy",  c, 32'(busy), 32'(exp_busy));
            chk("flush_valid", c, 32'(m_valid), 32'(exp_mv));
            if ((c >= 2) && (c <= 5)) chk("flush_data_pre", c, 32'(m_data), 32'h30 + 32'(c - 2));
            if ((c >= 18) && (c <= 21)) chk("flush_data_post", c, 32'(m_data), 32'h50 + 32'(c - 18));
`ifdef SYNC_FIFO_RD_CNT_EN
            if (c == 5)  chk("flush_count_before", c, 32'(rd_count), 32'd3);
            if (c == 14) chk("flush_count_cleared", c, 32'(rd_count), 32'd0);
            if (c == 22) chk("flush_count_after", c, 32'(rd_count), 32'd4);
`endif
        end
        flush = 1'b0;

        // ---------------- Test 6: reset mid-stream with a read in flight ----------------
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (c == 0) begin
                for (int k = 0; k < 6; k++) push(8'h60 + 8'(k));
            end
            m_ready = 1'b1;
            rst_n   = (c != 3);
            #1;
            if (c == 2) chk("rst_pre_data", c, 32'(m_data), 32'h60);
            if (c == 3) chk("rst_rd_en_forced", c, 32'(fifo_rd_en), 32'd0);
            if (c == 4) begin
                chk("rst_valid", c, 32'(m_valid), 32'd0);
                chk("rst_data",  c, 32'(m_data), 32'd0);
                chk("rst_busy",  c, 32'(busy), 32'd0);
                chk("rst_rd_en", c, 32'(fifo_rd_en), 32'd1);
`ifdef SYNC_FIFO_RD_CNT_EN
                chk("rst_count", c, 32'(rd_count), 32'd0);
`endif
            end
            if (c == 5) begin
                chk("rst_no_stale_valid", c, 32'(m_valid), 32'd0);
                chk("rst_no_stale_data",  c, 32'(m_data), 32'd0);
            end
            if (c == 6) begin
                chk("rst_resume_valid", c, 32'(m_valid), 32'd1);
                chk("rst_resume_data",  c, 32'(m_data), 32'h63);
            end
            if (c == 7) chk("rst_resume_data2", c, 32'(m_data), 32'h64);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
